// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data RAM for loads/stores, waits out
// the read latency and presents a registered writeback entry with valid/ready.
module mem_access_stage #(
  parameter int unsigned          ADDR_W     = 16,
  parameter int unsigned          DATA_W     = 24,
  parameter int unsigned          REG_W      = 4,
  parameter int unsigned          RD_LAT     = 1,
  parameter logic [ADDR_W-1:0]    ADDR_LIMIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_alu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [REG_W-1:0]  ld_rd_q;
  logic              ld_regwrite_q;
  logic              wb_valid_q;
  logic              wb_regwrite_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              fault_q;
  logic [ADDR_W-1:0] fault_addr_q;

  logic accept;
  logic is_load;
  logic is_store;
  logic oob;

  // A load flag wins over a store flag, so a dual-flagged op never writes.
  assign is_load  = ex_memtoreg;
  assign is_store = ex_memwrite && !ex_memtoreg;
  assign oob      = (ex_addr >= ADDR_LIMIT);

  assign ex_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
  assign accept   = ex_valid && ex_ready;

  assign ram_addr  = (state_q == READ_WAIT) ? ld_addr_q : ex_addr;
  assign ram_wdata = ex_wdata;
  assign ram_we    = !rst && accept && is_store && !oob;

  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_addr_q     <= '0;
      ld_rd_q       <= '0;
      ld_regwrite_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      if (accept && (is_load || is_store) && oob) begin
        fault_q <= 1'b1;
        if (!fault_q) fault_addr_q <= ex_addr;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_load && !oob) begin
              ld_addr_q     <= ex_addr;
              ld_rd_q       <= ex_rd;
              ld_regwrite_q <= ex_regwrite;
              cnt_q         <= LAT;
              wb_valid_q    <= 1'b0;
              state_q       <= READ_WAIT;
            end else begin
              // Store, pass-through, or out-of-bounds load (returns zero).
              wb_valid_q    <= 1'b1;
              wb_rd_q       <= ex_rd;
              wb_regwrite_q <= is_store ? 1'b0 : ex_regwrite;
              wb_data_q     <= is_store ? ex_wdata : (is_load ? '0 : ex_alu);
            end
          end else if (wb_ready) begin
            wb_valid_q <= 1'b0;
          end
        end
        READ_WAIT: begin
          if (cnt_q == 2'd1) begin
            wb_valid_q    <= 1'b1;
            wb_data_q     <= ram_rdata;
            wb_rd_q       <= ld_rd_q;
            wb_regwrite_q <= ld_regwrite_q;
            cnt_q         <= '0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: instance A (RD_LAT=1, ADDR_LIMIT=0x100)
// and instance B (RD_LAT=3, default limit) share stimulus, each with its own RAM.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_memwrite, ex_memtoreg, ex_regwrite, wb_ready;
  logic [3:0]  ex_rd;
  logic [15:0] ex_addr;
  logic [23:0] ex_wdata, ex_alu;

  logic        ex_ready_a, ram_we_a, wb_valid_a, wb_regwrite_a, fault_a;
  logic [15:0] ram_addr_a, fault_addr_a;
  logic [23:0] ram_wdata_a, ram_rdata_a, wb_data_a;
  logic [3:0]  wb_rd_a;

  logic        ex_ready_b, ram_we_b, wb_valid_b, wb_regwrite_b, fault_b;
  logic [15:0] ram_addr_b, fault_addr_b;
  logic [23:0] ram_wdata_b, ram_rdata_b, wb_data_b;
  logic [3:0]  wb_rd_b;

  logic [23:0] mem_a [0:65535];
  logic [23:0] mem_b [0:65535];

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  mem_access_stage #(.RD_LAT(1), .ADDR_LIMIT(16'h0100)) u_dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready_a),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_we(ram_we_a),
    .ram_rdata(ram_rdata_a), .wb_valid(wb_valid_a), .wb_ready(wb_ready),
    .wb_regwrite(wb_regwrite_a), .wb_rd(wb_rd_a), .wb_data(wb_data_a),
    .fault(fault_a), .fault_addr(fault_addr_a)
  );

  mem_access_stage #(.RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready_b),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b),
    .ram_rdata(ram_rdata_b), .wb_valid(wb_valid_b), .wb_ready(wb_ready),
    .wb_regwrite(wb_regwrite_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b),
    .fault(fault_b), .fault_addr(fault_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models: data for the address seen at an edge is valid next cycle.
  always @(posedge clk) begin
    if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
    ram_rdata_a <= mem_a[ram_addr_a];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    ram_rdata_b <= mem_b[ram_addr_b];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_memwrite = 1'b0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
    ex_rd = '0; ex_addr = '0; ex_wdata = '0; ex_alu = '0;
  endtask

  task automatic op(input logic w, input logic l, input logic rw, input logic [3:0] rd,
                    input logic [15:0] a, input logic [23:0] wd, input logic [23:0] alu);
    ex_valid = 1'b1; ex_memwrite = w; ex_memtoreg = l; ex_regwrite = rw;
    ex_rd = rd; ex_addr = a; ex_wdata = wd; ex_alu = alu;
  endtask

  initial begin
    idle();
    wb_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    op(1, 0, 0, 4'd0, 16'h0001, 24'h000055, '0);
    settle();
    check("rst_we", ram_we_a, 0);
    check("rst_wb_valid", wb_valid_a, 0);
    check("rst_wb_data", wb_data_a, 0);
    check("rst_wb_rd", wb_rd_a, 0);
    check("rst_wb_regwrite", wb_regwrite_a, 0);
    check("rst_fault", fault_a, 0);
    check("rst_fault_addr", fault_addr_a, 0);
    step();
    rst = 1'b0; idle();
    settle();
    check("post_rst_ready", ex_ready_a, 1);
    check("post_rst_wb_valid", wb_valid_a, 0);
    step();

    // Store then load at 0x0001
    op(1, 0, 0, 4'd0, 16'h0001, 24'h00000F, '0);
    settle();
    check("st_we", ram_we_a, 1);
    step(); idle(); settle();
    check("st_we_drop", ram_we_a, 0);
    check("st_wb_valid", wb_valid_a, 1);
    check("st_wb_data", wb_data_a, 24'h00000F);
    check("st_wb_regwrite", wb_regwrite_a, 0);
    step();
    op(0, 1, 1, 4'd5, 16'h0001, '0, '0);
    settle();
    check("ld_ready", ex_ready_a, 1);
    check("ld_we", ram_we_a, 0);
    step(); idle(); settle();
    check("ld_wait_valid", wb_valid_a, 0);
    check("ld_wait_ready", ex_ready_a, 0);
    step(); settle();
    check("ld_wb_valid", wb_valid_a, 1);
    check("ld_wb_data", wb_data_a, 24'h00000F);
    check("ld_wb_rd", wb_rd_a, 5);
    check("ld_wb_regwrite", wb_regwrite_a, 1);
    step(); settle();
    check("ld_retire", wb_valid_a, 0);
    step();

    // Back-to-back pass-throughs
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 1, 4'(i + 1), 16'h0000, '0, 24'(5 + i));
      settle();
      check("pt_ready", ex_ready_a, 1);
      if (i > 0) check("pt_data", wb_data_a, 32'(4 + i));
      step();
    end
    idle(); settle();
    check("pt_last_data", wb_data_a, 7);
    check("pt_last_rd", wb_rd_a, 3);
    check("pt_last_valid", wb_valid_a, 1);
    step();

    // Backpressure hold
    op(0, 0, 1, 4'd4, 16'h0000, '0, 24'hABCDEF);
    wb_ready = 1'b0;
    settle();
    check("bp_accept_ready", ex_ready_a, 1);
    step();
    op(1, 0, 0, 4'd0, 16'h0002, 24'h111111, '0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check("bp_hold_data", wb_data_a, 24'hABCDEF);
      check("bp_hold_valid", wb_valid_a, 1);
      check("bp_ready_low", ex_ready_a, 0);
      check("bp_we_low", ram_we_a, 0);
      step();
    end
    idle(); wb_ready = 1'b1;
    settle();
    check("bp_present", wb_valid_a, 1);
    step(); settle();
    check("bp_retired", wb_valid_a, 0);
    step();

    // Dual-flagged op behaves as a load
    op(1, 0, 0, 4'd0, 16'h0003, 24'h123456, '0);
    settle();
    check("dual_pre_we", ram_we_a, 1);
    step();
    op(1, 1, 1, 4'd7, 16'h0003, 24'h999999, '0);
    settle();
    check("dual_we", ram_we_a, 0);
    step(); idle(); settle();
    check("dual_wait", ex_ready_a, 0);
    step(); settle();
    check("dual_valid", wb_valid_a, 1);
    check("dual_data", wb_data_a, 24'h123456);
    check("dual_rd", wb_rd_a, 7);
    step();

    // Bounds checking (limit 0x0100)
    op(1, 0, 0, 4'd0, 16'h00FF, 24'h000001, '0);
    settle();
    check("oob_edge_in_we", ram_we_a, 1);
    step();
    op(1, 0, 0, 4'd0, 16'h0200, 24'h000002, '0);
    settle();
    check("oob_200_we", ram_we_a, 0);
    step();
    op(1, 0, 0, 4'd0, 16'h0300, 24'h000003, '0);
    settle();
    check("oob_300_we", ram_we_a, 0);
    check("oob_fault", fault_a, 1);
    check("oob_fault_addr", fault_addr_a, 16'h0200);
    check("oob_st_regwrite", wb_regwrite_a, 0);
    step();
    op(1, 0, 0, 4'd0, 16'h0100, 24'h000004, '0);
    settle();
    check("oob_edge_we", ram_we_a, 0);
    step();
    op(0, 1, 1, 4'd6, 16'h0150, '0, '0);
    settle();
    check("oob_ld_we", ram_we_a, 0);
    step(); idle(); settle();
    check("oob_ld_valid", wb_valid_a, 1);
    check("oob_ld_data", wb_data_a, 0);
    check("oob_ld_regwrite", wb_regwrite_a, 1);
    check("oob_ld_rd", wb_rd_a, 6);
    check("oob_ld_no_wait", ex_ready_a, 1);
    check("oob_sticky", fault_a, 1);
    check("oob_first_addr", fault_addr_a, 16'h0200);
    step();

    // RD_LAT=3 instance: normal load latency, then reset mid-wait
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    op(1, 0, 0, 4'd0, 16'h0020, 24'h0ABCDE, '0);
    settle();
    check("l3_st_we", ram_we_b, 1);
    step();
    op(0, 1, 1, 4'd9, 16'h0020, '0, '0);
    settle();
    check("l3_ld_ready", ex_ready_b, 1);
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("l3_wait_valid", wb_valid_b, 0);
      step();
    end
    settle();
    check("l3_valid", wb_valid_b, 1);
    check("l3_data", wb_data_b, 24'h0ABCDE);
    check("l3_rd", wb_rd_b, 9);
    step(); step();

    op(0, 1, 1, 4'd2, 16'h0010, '0, '0);
    settle();
    check("abort_ld_ready", ex_ready_b, 1);
    step(); idle(); settle();
    step();
    rst = 1'b1;
    settle();
    check("abort_rst_we", ram_we_b, 0);
    step();
    rst = 1'b0;
    settle();
    check("abort_ready", ex_ready_b, 1);
    check("abort_valid", wb_valid_b, 0);
    check("abort_data", wb_data_b, 0);
    check("abort_rd", wb_rd_b, 0);
    check("abort_regwrite", wb_regwrite_b, 0);
    check("abort_fault", fault_b, 0);
    check("abort_fault_addr", fault_addr_b, 0);
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      check("abort_never_valid", wb_valid_b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
